clkdiv_multi: RTL and testbench

CLKDIV_MULTI -- requirements
Module: clkdiv_multi

---
 rtl/clkdiv_pkg.sv | 12 +
 rtl/clkdiv_ch.sv | 120 ++++++++++++
 rtl/clkdiv_multi.sv | 34 +++
 tb/tb_clkdiv_multi.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    PEND     = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clkdiv_ch.sv
// One divider channel: counter, active/pending ratio, registered strobe and divided clock.
// Optional phase-slip support is compiled in with CLKDIV_CALIB_EN.
module clkdiv_ch
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             hclkin,
  input  logic             reset,
  input  logic             sync,
  input  logic             load,
  input  logic [DIV_W-1:0] ratio,
  input  logic             calib,
  output logic             ce_out,
  output logic             clk_out,
  output logic             busy
);

  ch_state_e        state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] act, act_nxt;
  logic [DIV_W-1:0] pend, pend_nxt;
  logic [DIV_W:0]   half_nxt;
  logic             ce_nxt, clk_nxt, hold, wrap;

`ifdef CLKDIV_CALIB_EN
  assign hold = calib && (state != DISABLED);
`else
  logic unused_calib;
  assign unused_calib = calib;
  assign hold         = 1'b0;
`endif

  // A held cycle never wraps, so a slip at R-1 delays the strobe too.
  assign wrap = (state != DISABLED) && !hold && (cnt == act - DIV_W'(1));

  always_ff @(posedge hclkin) begin
    if (reset) begin
      state   <= DISABLED;
      cnt     <= '0;
      act     <= '0;
      pend    <= '0;
      ce_out  <= 1'b0;
      clk_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      act     <= act_nxt;
      pend    <= pend_nxt;
      ce_out  <= ce_nxt;
      clk_out <= clk_nxt;
      busy    <= (state_nxt == PEND);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    act_nxt   = act;
    pend_nxt  = pend;
    if (sync) begin
      // Realign: a coincident load beats the pending value.
      cnt_nxt  = '0;
      pend_nxt = '0;
      if (load)                act_nxt = ratio;
      else if (state == PEND)  act_nxt = pend;
      state_nxt = (act_nxt == '0) ? DISABLED : RUN;
    end else begin
      case (state)
        DISABLED: begin
          if (load) begin
            act_nxt   = ratio;
            state_nxt = (ratio == '0) ? DISABLED : RUN;
          end
        end
        RUN: begin
          if (wrap)       cnt_nxt = '0;
          else if (!hold) cnt_nxt = cnt + DIV_W'(1);
          if (load) begin
            pend_nxt  = ratio;
            state_nxt = PEND;
          end
        end
        PEND: begin
          if (wrap) begin
            cnt_nxt = '0;
            if (pend != '0) begin
              act_nxt   = pend;
              state_nxt = load ? PEND : RUN;
              if (load) pend_nxt = ratio;
            end else if (load) begin
              // Pending disable lands with a new load: treat as a load into DISABLED.
              act_nxt   = ratio;
              state_nxt = (ratio == '0) ? DISABLED : RUN;
            end else begin
              act_nxt   = '0;
              state_nxt = DISABLED;
            end
          end else begin
            if (!hold) cnt_nxt = cnt + DIV_W'(1);
            if (load)  pend_nxt = ratio;
          end
        end
        default: begin
          state_nxt = DISABLED;
          cnt_nxt   = '0;
          act_nxt   = '0;
        end
      endcase
    end

    // Strobe only on a natural wrap; a sync restart does not strobe.
    ce_nxt   = wrap && !sync && (state_nxt != DISABLED);
    half_nxt = ({1'b0, act_nxt} + (DIV_W+1)'(1)) >> 1;
    clk_nxt  = (state_nxt != DISABLED) && (act_nxt != DIV_W'(1)) &&
               ({1'b0, cnt_nxt} < half_nxt);
  end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider; one clkdiv_ch per channel, shared sync.
// Define CLKDIV_CALIB_EN to enable per-channel calib phase slips.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = DIV_W_DEF
) (
  input  logic                    hclkin,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       div_busy,
  input  logic                    sync,
  input  logic [NUM_CH-1:0]       calib,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       clk_out
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_ch #(.DIV_W(DIV_W)) u_ch (
      .hclkin  (hclkin),
      .reset   (reset),
      .sync    (sync),
      .load    (div_load[i]),
      .ratio   (div_ratio[i*DIV_W +: DIV_W]),
      .calib   (calib[i]),
      .ce_out  (ce_out[i]),
      .clk_out (clk_out[i]),
      .busy    (div_busy[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Testbench for clkdiv_multi: directed scenarios plus randomized run against a period-level model.
module tb_clkdiv_multi;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DIV_W  = 8;
`ifdef CLKDIV_CALIB_EN
  localparam bit CAL_EN = 1'b1;
`else
  localparam bit CAL_EN = 1'b0;
`endif

  logic                    hclkin = 1'b0;
  logic                    reset, sync;
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic [NUM_CH-1:0]       div_load, calib, div_busy, ce_out, clk_out;

  int total = 0;
  int bad   = 0;

  // Reference model: ratio in force, position within the period, optional pending ratio.
  int               m_r  [NUM_CH];
  int               m_ph [NUM_CH];
  int               m_pv [NUM_CH];
  bit               m_hp [NUM_CH];
  logic [NUM_CH-1:0] exp_ce, exp_clk, exp_busy;

  always #5 hclkin = ~hclkin;

  clkdiv_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .hclkin    (hclkin),
    .reset     (reset),
    .div_ratio (div_ratio),
    .div_load  (div_load),
    .div_busy  (div_busy),
    .sync      (sync),
    .calib     (calib),
    .ce_out    (ce_out),
    .clk_out   (clk_out)
  );

  task automatic tick();
    @(posedge hclkin);
    #1;
  endtask

  task automatic idle_inputs();
    reset    = 1'b0;
    sync     = 1'b0;
    div_load = '0;
    calib    = '0;
  endtask

  task automatic set_ratio(input int ch, input int r);
    div_ratio[ch*DIV_W +: DIV_W] = DIV_W'(r);
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      int ld_r;
      bit ld, wrapped;
      ld      = div_load[i];
      ld_r    = int'(div_ratio[i*DIV_W +: DIV_W]);
      wrapped = 1'b0;
      if (reset) begin
        m_r[i] = 0; m_ph[i] = 0; m_hp[i] = 1'b0;
      end else if (sync) begin
        if (ld)           m_r[i] = ld_r;
        else if (m_hp[i]) m_r[i] = m_pv[i];
        m_hp[i] = 1'b0; m_ph[i] = 0;
      end else if (m_r[i] == 0) begin
        if (ld) m_r[i] = ld_r;
        m_ph[i] = 0;
      end else if (CAL_EN && calib[i]) begin
        if (ld) begin m_hp[i] = 1'b1; m_pv[i] = ld_r; end
      end else begin
        m_ph[i] = (m_ph[i] + 1) % m_r[i];
        wrapped = (m_ph[i] == 0);
        if (wrapped && m_hp[i]) begin m_r[i] = m_pv[i]; m_hp[i] = 1'b0; end
        if (ld) begin
          if (wrapped && m_r[i] == 0) m_r[i] = ld_r;
          else begin m_hp[i] = 1'b1; m_pv[i] = ld_r; end
        end
      end
      exp_ce[i]   = wrapped && (m_r[i] != 0);
      exp_clk[i]  = (m_r[i] > 1) && (m_ph[i] < (m_r[i] + 1) / 2);
      exp_busy[i] = m_hp[i];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (ce_out !== '0 || clk_out !== '0 || div_busy !== '0) begin
      bad++;
      $display("FAIL reset ce=%b clk=%b busy=%b required all 0", ce_out, clk_out, div_busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_r4();
    bit e_ce, e_clk;
    set_ratio(0, 4);
    div_load = 4'b0001;
    tick();
    div_load = '0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick();
      e_ce  = (k > 0) && (k % 4 == 0);
      e_clk = (k % 4) < 2;
      total++;
      if (ce_out[0] !== e_ce || clk_out[0] !== e_clk || div_busy[0] !== 1'b0) begin
        bad++;
        $display("FAIL load_r4 k=%0d ce=%b/%b clk=%b/%b busy=%b/0", k, ce_out[0], e_ce,
                 clk_out[0], e_clk, div_busy[0]);
      end
    end
  endtask

  task automatic test_reload();
    bit e_ce, e_clk, e_busy;
    tick();
    set_ratio(0, 3);
    div_load = 4'b0001;
    tick();
    div_load = '0;
    for (int j = 0; j <= 8; j++) begin
      if (j > 0) tick();
      e_busy = (j < 2);
      e_ce   = (j >= 2) && ((j - 2) % 3 == 0);
      e_clk  = (j >= 2) && ((j - 2) % 3 < 2);
      total++;
      if (ce_out[0] !== e_ce || clk_out[0] !== e_clk || div_busy[0] !== e_busy) begin
        bad++;
        $display("FAIL reload j=%0d ce=%b/%b clk=%b/%b busy=%b/%b", j, ce_out[0], e_ce,
                 clk_out[0], e_clk, div_busy[0], e_busy);
      end
    end
  endtask

  task automatic test_sync();
    logic [1:0] e_ce, e_clk;
    set_ratio(0, 4);
    set_ratio(1, 6);
    div_load = 4'b0011;
    sync     = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (div_busy[1:0] !== 2'b00 || clk_out[1:0] !== 2'b11 || ce_out[1:0] !== 2'b00) begin
      bad++;
      $display("FAIL sync_load busy=%b/00 clk=%b/11 ce=%b/00", div_busy[1:0], clk_out[1:0],
               ce_out[1:0]);
    end
    tick();
    tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick();
      e_ce[0]  = (k > 0) && (k % 4 == 0);
      e_ce[1]  = (k > 0) && (k % 6 == 0);
      e_clk[0] = (k % 4) < 2;
      e_clk[1] = (k % 6) < 3;
      total++;
      if (ce_out[1:0] !== e_ce || clk_out[1:0] !== e_clk) begin
        bad++;
        $display("FAIL sync_align k=%0d ce=%b/%b clk=%b/%b", k, ce_out[1:0], e_ce,
                 clk_out[1:0], e_clk);
      end
    end
  endtask

  task automatic test_r1();
    set_ratio(3, 1);
    div_load = 4'b1000;
    tick();
    div_load = '0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      total++;
      if (ce_out[3] !== (k > 0) || clk_out[3] !== 1'b0 || div_busy[3] !== 1'b0) begin
        bad++;
        $display("FAIL r1 k=%0d ce=%b/%b clk=%b/0 busy=%b/0", k, ce_out[3], (k > 0),
                 clk_out[3], div_busy[3]);
      end
    end
    set_ratio(3, 0);
    div_load = 4'b1000;
    tick();
    div_load = '0;
    total++;
    if (ce_out[3] !== 1'b1 || div_busy[3] !== 1'b1 || clk_out[3] !== 1'b0) begin
      bad++;
      $display("FAIL r0_pending ce=%b/1 busy=%b/1 clk=%b/0", ce_out[3], div_busy[3], clk_out[3]);
    end
    for (int z = 1; z <= 3; z++) begin
      tick();
      total++;
      if (ce_out[3] !== 1'b0 || div_busy[3] !== 1'b0 || clk_out[3] !== 1'b0) begin
        bad++;
        $display("FAIL r0_disabled z=%0d ce=%b busy=%b clk=%b required 0", z, ce_out[3],
                 div_busy[3], clk_out[3]);
      end
    end
  endtask

  task automatic test_reset_pend();
    set_ratio(2, 5);
    div_load = 4'b0100;
    tick();
    div_load = '0;
    tick();
    set_ratio(2, 7);
    div_load = 4'b0100;
    tick();
    div_load = '0;
    total++;
    if (div_busy[2] !== 1'b1) begin
      bad++;
      $display("FAIL pend_busy busy=%b required 1", div_busy[2]);
    end
    reset = 1'b1;
    sync  = 1'b1;
    tick();
    idle_inputs();
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick();
      total++;
      if (ce_out !== '0 || clk_out !== '0 || div_busy !== '0) begin
        bad++;
        $display("FAIL reset_pend k=%0d ce=%b clk=%b busy=%b required all 0", k, ce_out,
                 clk_out, div_busy);
      end
    end
  endtask

  task automatic test_max();
    bit e_ce, e_clk;
    set_ratio(1, 255);
    div_load = 4'b0010;
    tick();
    div_load = '0;
    for (int k = 0; k <= 260; k++) begin
      if (k > 0) tick();
      e_ce  = (k > 0) && (k % 255 == 0);
      e_clk = (k % 255) < 128;
      total++;
      if (ce_out[1] !== e_ce || clk_out[1] !== e_clk) begin
        bad++;
        $display("FAIL max_ratio k=%0d ce=%b/%b clk=%b/%b", k, ce_out[1], e_ce, clk_out[1], e_clk);
      end
    end
  endtask

  task automatic test_calib();
    bit e_ce, e_clk;
    int pos;
    set_ratio(0, 5);
    div_load = 4'b0001;
    tick();
    div_load = '0;
    for (int k = 0; k <= 21; k++) begin
      if (k > 0) begin
        if (k == 7) calib[0] = 1'b1;
        tick();
        calib[0] = 1'b0;
      end
      pos   = (CAL_EN && k >= 7) ? (k - 1) % 5 : k % 5;
      e_ce  = (k > 0) && (pos == 0) && !(CAL_EN && k == 10);
      e_clk = pos < 3;
      total++;
      if (ce_out[0] !== e_ce || clk_out[0] !== e_clk) begin
        bad++;
        $display("FAIL calib k=%0d ce=%b/%b clk=%b/%b", k, ce_out[0], e_ce, clk_out[0], e_clk);
      end
    end
  endtask

  task automatic test_random();
    int v;
    reset = 1'b1;
    model_step();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        v = int'($urandom_range(15));
        set_ratio(i, (v <= 10) ? v : (v <= 13) ? 1 : (v == 14) ? 0 : 255);
        div_load[i] = ($urandom_range(7) == 0);
        calib[i]    = ($urandom_range(9) == 0);
      end
      sync  = ($urandom_range(39) == 0);
      reset = ($urandom_range(299) == 0);
      model_step();
      tick();
      total++;
      if (ce_out !== exp_ce || clk_out !== exp_clk || div_busy !== exp_busy) begin
        bad++;
        if (bad < 20)
          $display("FAIL random c=%0d ce=%b/%b clk=%b/%b busy=%b/%b", c, ce_out, exp_ce,
                   clk_out, exp_clk, div_busy, exp_busy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    div_ratio = '0;
    test_reset();
    test_load_r4();
    test_reload();
    test_sync();
    test_r1();
    test_reset_pend();
    test_max();
    test_calib();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
